park_controller: RTL and testbench

PARK_CONTROLLER -- requirements
Module: park_controller

---
 rtl/park_pkg.sv | 18 +
 rtl/park_controller_if.sv | 35 +++
 rtl/park_floor_ctr.sv | 38 +++
 rtl/park_controller.sv | 147 ++++++++++++++
 tb/tb_park_controller.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared types, default parameters and width helper for the parking controller
package park_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN     = 2'd1,
    WAIT_REL = 2'd2
  } gate_state_t;

  localparam int DEF_NUM_FLOORS      = 4;
  localparam int DEF_SPOTS_PER_FLOOR = 8;
  localparam int DEF_GATE_CYCLES     = 3;

  function automatic int floor_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/park_controller_if.sv
// rtl/park_controller_if.sv - entry/exit requests and occupancy status bundle
interface park_controller_if
  import park_pkg::*;
#(
  parameter int FLOOR_W = floor_width(DEF_NUM_FLOORS),
  parameter int SPOT_W  = $clog2(DEF_SPOTS_PER_FLOOR + 1),
  parameter int TOT_W   = $clog2(DEF_NUM_FLOORS * DEF_SPOTS_PER_FLOOR + 1)
);

  logic               car_in;
  logic               car_out;
  logic [FLOOR_W-1:0] out_floor;
  logic [SPOT_W-1:0]  free_spot;
  logic [FLOOR_W-1:0] current_floor;
  logic [TOT_W-1:0]   total_free;
  logic               parking_full;
  logic               gate_open;
  logic               in_ack;
  logic [FLOOR_W-1:0] assigned_floor;
  logic               in_reject;
  logic               out_err;

  modport master (
    output car_in, car_out, out_floor,
    input  free_spot, current_floor, total_free, parking_full,
    input  gate_open, in_ack, assigned_floor, in_reject, out_err
  );

  modport slave (
    input  car_in, car_out, out_floor,
    output free_spot, current_floor, total_free, parking_full,
    output gate_open, in_ack, assigned_floor, in_reject, out_err
  );

endinterface

// File: rtl/park_floor_ctr.sv
// rtl/park_floor_ctr.sv - saturating occupancy counter for a single floor
module park_floor_ctr
  import park_pkg::*;
#(
  parameter int SPOTS_PER_FLOOR = DEF_SPOTS_PER_FLOOR,
  parameter int SPOT_W          = $clog2(SPOTS_PER_FLOOR + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [SPOT_W-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [SPOT_W-1:0] r_count;
  logic              w_do_inc;
  logic              w_do_dec;

  assign full     = (r_count == SPOT_W'(SPOTS_PER_FLOOR));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_do_inc = inc && !full;
  assign w_do_dec = dec && !empty;

  // A legal admit and a legal exit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_do_inc && !w_do_dec) begin
      r_count <= r_count + SPOT_W'(1);
    end else if (w_do_dec && !w_do_inc) begin
      r_count <= r_count - SPOT_W'(1);
    end
  end

endmodule

// File: rtl/park_controller.sv
// rtl/park_controller.sv - multi-floor car park: entry gate FSM, exit handling, free-spot status
module park_controller
  import park_pkg::*;
#(
  parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
  parameter int SPOTS_PER_FLOOR = DEF_SPOTS_PER_FLOOR,
  parameter int GATE_CYCLES     = DEF_GATE_CYCLES,
  localparam int FLOOR_W = floor_width(NUM_FLOORS),
  localparam int SPOT_W  = $clog2(SPOTS_PER_FLOOR + 1),
  localparam int TOT_W   = $clog2(NUM_FLOORS * SPOTS_PER_FLOOR + 1)
) (
  input logic               clk,
  input logic               rst,
  park_controller_if.slave  bus
);

  localparam int GCNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  gate_state_t        r_state;
  gate_state_t        w_next_state;
  logic [GCNT_W-1:0]  r_gate_cnt;
  logic               r_car_out_prev;
  logic               r_in_ack;
  logic               r_in_reject;
  logic               r_out_err;
  logic [FLOOR_W-1:0] r_assigned_floor;

  logic [SPOT_W-1:0]     w_count [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] w_full;
  logic [NUM_FLOORS-1:0] w_empty;
  logic [NUM_FLOORS-1:0] w_inc;
  logic [NUM_FLOORS-1:0] w_dec;
  logic [FLOOR_W-1:0]    w_cur_floor;
  logic [SPOT_W-1:0]     w_cur_count;
  logic [TOT_W-1:0]      w_total_free;
  logic                  w_parking_full;
  logic                  w_gate_last;
  logic                  w_admit;
  logic                  w_reject;
  logic                  w_exit_edge;
  logic                  w_floor_ok;
  logic                  w_sel_empty;
  logic                  w_exit_ok;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    assign w_inc[f] = w_admit && (w_cur_floor == FLOOR_W'(f));
    assign w_dec[f] = w_exit_ok && (bus.out_floor == FLOOR_W'(f));

    park_floor_ctr #(
      .SPOTS_PER_FLOOR (SPOTS_PER_FLOOR),
      .SPOT_W          (SPOT_W)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc[f]),
      .dec   (w_dec[f]),
      .count (w_count[f]),
      .full  (w_full[f]),
      .empty (w_empty[f])
    );
  end

  // Scanning downward leaves the lowest non-full floor selected; floor 0 when all are full.
  always_comb begin
    w_cur_floor = '0;
    w_cur_count = w_count[0];
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (!w_full[f]) begin
        w_cur_floor = FLOOR_W'(f);
        w_cur_count = w_count[f];
      end
    end
  end

  always_comb begin
    w_total_free = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_total_free = w_total_free + (TOT_W'(SPOTS_PER_FLOOR) - TOT_W'(w_count[f]));
    end
  end

  // Matching out_floor against each valid index also rejects out-of-range floors.
  always_comb begin
    w_floor_ok  = 1'b0;
    w_sel_empty = 1'b1;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (bus.out_floor == FLOOR_W'(f)) begin
        w_floor_ok  = 1'b1;
        w_sel_empty = w_empty[f];
      end
    end
  end

  assign w_parking_full = &w_full;
  assign w_exit_edge    = bus.car_out && !r_car_out_prev;
  assign w_exit_ok      = w_exit_edge && w_floor_ok && !w_sel_empty;
  assign w_gate_last    = (r_gate_cnt == GCNT_W'(GATE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_gate_cnt       <= '0;
      r_car_out_prev   <= 1'b0;
      r_in_ack         <= 1'b0;
      r_in_reject      <= 1'b0;
      r_out_err        <= 1'b0;
      r_assigned_floor <= '0;
    end else begin
      r_state        <= w_next_state;
      r_gate_cnt     <= ((r_state == OPEN) && !w_gate_last) ? r_gate_cnt + GCNT_W'(1) : '0;
      r_car_out_prev <= bus.car_out;
      r_in_ack       <= w_admit;
      r_in_reject    <= w_reject;
      r_out_err      <= w_exit_edge && !w_exit_ok;
      if (w_admit) begin
        r_assigned_floor <= w_cur_floor;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (bus.car_in) w_next_state = w_parking_full ? WAIT_REL : OPEN;
      OPEN:     if (w_gate_last) w_next_state = WAIT_REL;
      WAIT_REL: if (!bus.car_in) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Admission is decided on pre-update occupancy, so a same-cycle exit cannot rescue a reject.
  always_comb begin
    w_admit  = (r_state == IDLE) && bus.car_in && !w_parking_full;
    w_reject = (r_state == IDLE) && bus.car_in && w_parking_full;
  end

  assign bus.gate_open      = (r_state == OPEN);
  assign bus.in_ack         = r_in_ack;
  assign bus.in_reject      = r_in_reject;
  assign bus.out_err        = r_out_err;
  assign bus.assigned_floor = r_assigned_floor;
  assign bus.free_spot      = SPOT_W'(SPOTS_PER_FLOOR) - w_cur_count;
  assign bus.current_floor  = w_cur_floor;
  assign bus.total_free     = w_total_free;
  assign bus.parking_full   = w_parking_full;

endmodule

// File: tb/tb_park_controller.sv
// tb/tb_park_controller.sv - self-checking bench for park_controller at default parameters
module tb_park_controller;
  import park_pkg::*;

  localparam int NF = 4;
  localparam int SP = 8;
  localparam int GC = 3;
  localparam int FW = 2;
  localparam int SW = 4;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  park_controller_if #(.FLOOR_W(FW), .SPOT_W(SW), .TOT_W(TW)) bus ();

  park_controller #(
    .NUM_FLOORS      (NF),
    .SPOTS_PER_FLOOR (SP),
    .GATE_CYCLES     (GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: car counts per floor plus how long the gate still stays open
  // and whether the current request is still being held.
  int m_occ [NF];
  int m_gate_left;
  bit m_hold;
  bit m_prev_out;
  bit m_ack, m_rej, m_err;
  int m_af;

  typedef struct {
    bit ci;
    bit co;
    int of;
    int e_free;
    int e_floor;
    int e_total;
    bit e_ack;
    bit e_gate;
    bit e_err;
  } vec_t;

  vec_t vecs [10];

  function automatic int m_lowest();
    for (int f = 0; f < NF; f++) if (m_occ[f] < SP) return f;
    return -1;
  endfunction

  function automatic int m_used();
    int s = 0;
    for (int f = 0; f < NF; f++) s += m_occ[f];
    return s;
  endfunction

  task automatic model_step(input bit r, input bit ci, input bit co, input int of);
    int  low;
    bit  edge_seen, exit_ok;
    if (!r) begin
      for (int f = 0; f < NF; f++) m_occ[f] = 0;
      m_gate_left = 0; m_hold = 0; m_prev_out = 0;
      m_ack = 0; m_rej = 0; m_err = 0;
      return;
    end
    low = m_lowest();
    m_ack = 0; m_rej = 0; m_err = 0;
    edge_seen = co && !m_prev_out;
    m_prev_out = co;
    exit_ok = edge_seen && (of < NF) && (m_occ[of] > 0);
    if (m_gate_left > 0) begin
      m_gate_left--;
      if (m_gate_left == 0) m_hold = 1;
    end else if (m_hold) begin
      if (!ci) m_hold = 0;
    end else if (ci) begin
      if (low >= 0) begin
        m_occ[low]++;
        m_ack = 1; m_af = low; m_gate_left = GC;
      end else begin
        m_rej = 1; m_hold = 1;
      end
    end
    if (exit_ok) m_occ[of]--;
    else if (edge_seen) m_err = 1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    int low = m_lowest();
    chk({nm, " free_spot"}, int'(bus.free_spot), (low >= 0) ? SP - m_occ[low] : 0);
    chk({nm, " current_floor"}, int'(bus.current_floor), (low >= 0) ? low : 0);
    chk({nm, " total_free"}, int'(bus.total_free), NF * SP - m_used());
    chk({nm, " parking_full"}, int'(bus.parking_full), int'(low < 0));
    chk({nm, " gate_open"}, int'(bus.gate_open), int'(m_gate_left > 0));
    chk({nm, " in_ack"}, int'(bus.in_ack), int'(m_ack));
    chk({nm, " in_reject"}, int'(bus.in_reject), int'(m_rej));
    chk({nm, " out_err"}, int'(bus.out_err), int'(m_err));
    if (m_ack) chk({nm, " assigned_floor"}, int'(bus.assigned_floor), m_af);
  endtask

  task automatic cycle(input bit r, input bit ci, input bit co, input int of);
    rst           = r;
    bus.car_in    = ci;
    bus.car_out   = co;
    bus.out_floor = FW'(of);
    @(posedge clk);
    model_step(r, ci, co, of);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic admit_car();
    cycle(1'b1, 1'b1, 1'b0, 0);
    for (int k = 0; k < GC + 1; k++) cycle(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int acks;
    rst = 1'b0;
    bus.car_in = 1'b0; bus.car_out = 1'b0; bus.out_floor = '0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 0);
    chk("reset free_spot", int'(bus.free_spot), 8);
    chk("reset current_floor", int'(bus.current_floor), 0);
    chk("reset total_free", int'(bus.total_free), 32);
    chk("reset parking_full", int'(bus.parking_full), 0);
    chk("reset gate_open", int'(bus.gate_open), 0);
    chk("reset pulses", int'({bus.in_ack, bus.in_reject, bus.out_err}), 0);

    vecs[0] = '{1, 0, 0, 7, 0, 31, 1, 1, 0};
    vecs[1] = '{0, 0, 0, 7, 0, 31, 0, 1, 0};
    vecs[2] = '{0, 0, 0, 7, 0, 31, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 7, 0, 31, 0, 0, 0};
    vecs[4] = '{0, 1, 0, 8, 0, 32, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 8, 0, 32, 0, 0, 0};
    vecs[6] = '{0, 0, 0, 8, 0, 32, 0, 0, 0};
    vecs[7] = '{0, 1, 1, 8, 0, 32, 0, 0, 1};
    vecs[8] = '{1, 0, 0, 7, 0, 31, 1, 1, 0};
    vecs[9] = '{1, 0, 0, 7, 0, 31, 0, 1, 0};
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].ci, vecs[i].co, vecs[i].of);
      chk($sformatf("vec%0d free_spot", i), int'(bus.free_spot), vecs[i].e_free);
      chk($sformatf("vec%0d current_floor", i), int'(bus.current_floor), vecs[i].e_floor);
      chk($sformatf("vec%0d total_free", i), int'(bus.total_free), vecs[i].e_total);
      chk($sformatf("vec%0d in_ack", i), int'(bus.in_ack), int'(vecs[i].e_ack));
      chk($sformatf("vec%0d gate_open", i), int'(bus.gate_open), int'(vecs[i].e_gate));
      chk($sformatf("vec%0d out_err", i), int'(bus.out_err), int'(vecs[i].e_err));
      if (vecs[i].e_ack) chk($sformatf("vec%0d assigned_floor", i), int'(bus.assigned_floor), 0);
    end

    do_reset();
    acks = 0;
    for (int k = 0; k < 13; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 0);
      acks += int'(bus.in_ack);
    end
    chk("held car_in ack count", acks, 1);
    chk("held car_in gate closed", int'(bus.gate_open), 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    chk("after release in_ack", int'(bus.in_ack), 1);
    chk("after release total_free", int'(bus.total_free), 30);

    do_reset();
    for (int k = 0; k < 8; k++) admit_car();
    chk("8 admits current_floor", int'(bus.current_floor), 1);
    chk("8 admits free_spot", int'(bus.free_spot), 8);
    for (int k = 0; k < 24; k++) admit_car();
    chk("32 admits parking_full", int'(bus.parking_full), 1);
    chk("32 admits total_free", int'(bus.total_free), 0);
    cycle(1'b1, 1'b1, 1'b1, 0);
    chk("33rd in_reject", int'(bus.in_reject), 1);
    chk("33rd in_ack", int'(bus.in_ack), 0);
    chk("33rd exit kept total", int'(bus.total_free), 1);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    chk("refill parking_full", int'(bus.parking_full), 1);
    cycle(1'b1, 1'b0, 1'b1, 2);
    chk("exit f2 current_floor", int'(bus.current_floor), 2);
    chk("exit f2 free_spot", int'(bus.free_spot), 1);
    chk("exit f2 parking_full", int'(bus.parking_full), 0);
    cycle(1'b1, 1'b0, 1'b1, 2);
    chk("held car_out total_free", int'(bus.total_free), 1);
    cycle(1'b1, 1'b0, 1'b0, 2);

    do_reset();
    for (int k = 0; k < 9; k++) admit_car();
    cycle(1'b1, 1'b1, 1'b1, 1);
    chk("same-cycle in_ack", int'(bus.in_ack), 1);
    chk("same-cycle assigned_floor", int'(bus.assigned_floor), 1);
    chk("same-cycle total_free", int'(bus.total_free), 23);
    chk("same-cycle free_spot", int'(bus.free_spot), 7);
    for (int k = 0; k < GC + 1; k++) cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b1, 3);
    chk("empty floor out_err", int'(bus.out_err), 1);
    chk("empty floor total_free", int'(bus.total_free), 23);
    cycle(1'b1, 1'b0, 1'b0, 0);

    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    chk("rst in OPEN gate_open", int'(bus.gate_open), 0);
    chk("rst in OPEN total_free", int'(bus.total_free), 32);
    cycle(1'b1, 1'b1, 1'b0, 0);
    chk("car_in through reset in_ack", int'(bus.in_ack), 1);
    chk("car_in through reset total_free", int'(bus.total_free), 31);

    for (int k = 0; k < 3000; k++) begin
      bit r, ci, co;
      r  = ($urandom_range(0, 199) != 0);
      ci = ($urandom_range(0, 2) != 0);
      co = (k < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      cycle(r, ci, co, int'($urandom_range(0, NF - 1)));
      check_model($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
